// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction prefetch queue with single-outstanding fetch FSM
module instr_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000FFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exception,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          flush;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_after_push;

  assign flush = redirect | exception;
  assign pop   = (count_q != '0) & ~stall & ~flush;
  // Data returning during a flush belongs to the old stream and is dropped.
  assign push  = (state_q == S_REQ) & imem_ack & ~flush & (count_q != FULL);
  // Occupancy after this cycle's push; decides whether to keep requesting.
  assign count_after_push = count_q + CW'(1) - CW'(pop);

  // Fetch FSM: next state, fetch PC and memory request outputs.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    imem_req    = 1'b0;
    imem_addr   = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (flush || (count_q != FULL)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (flush) begin
          // Without an ack the old request is still in flight; wait it out.
          if (!imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = fetch_pc_q;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after_push < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        // Keep the abandoned request's address stable until memory answers.
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (exception) begin
      fetch_pc_d = EXC_VECTOR;
    end else if (redirect) begin
      fetch_pc_d = redirect_pc;
    end
  end

  // Queue occupancy and pointer next-state; a flush empties the queue.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= '0;
      drop_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr_q]    : '0;
  assign if_instr = if_valid ? instr_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exception;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int          lat;
  int          wait_cnt;
  logic        ack_inject;

  int          errors;
  int          checks;
  int          cyc;
  int          push_cnt;
  logic [31:0] sb[$];
  int          pop_cyc[$];

  instr_fetch_queue #(.DEPTH(4), .EXC_VECTOR(32'h0000FFFC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exception   (exception),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + {a[7:0], a[31:8]};
  endfunction

  // Memory model: ack after 'lat' wait cycles, plus a stray-ack injection hook.
  assign imem_ack   = (imem_req && (wait_cnt == lat)) || ack_inject;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (imem_req) wait_cnt <= imem_ack ? 0 : wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Consume/compare at the end of the cycle, then advance to the next negedge.
  task automatic step();
    logic [31:0] e;
    if (reset && imem_req && imem_ack && !redirect && !exception) push_cnt++;
    if (reset && if_valid && !stall && !redirect && !exception) begin
      if (sb.size() == 0) begin
        check("sb_underflow", if_pc, 32'hDEAD_BEEF);
      end else begin
        e = sb.pop_front();
        check("if_pc", if_pc, e);
        check("if_instr", if_instr, mem_word(e));
        pop_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    redirect   = 1'b0;
    exception  = 1'b0;
    ack_inject = 1'b0;
    #1;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    stall = 1'b1;
  endtask

  initial begin
    int idx0;
    int base;
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    push_cnt    = 0;
    lat         = 0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    exception   = 1'b0;
    ack_inject  = 1'b0;
    reset       = 1'b0;

    // Reset values and zero-wait streaming
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    reset = 1'b1;
    check("idle_after_rst", {31'd0, imem_req}, 32'd0);
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    idx0 = pop_cyc.size();
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    drain(20);
    if (pop_cyc.size() >= idx0 + 4)
      check("pop_spacing", 32'(pop_cyc[idx0+3] - pop_cyc[idx0]), 32'd3);
    else
      check("pop_count", 32'(pop_cyc.size() - idx0), 32'd4);

    // Stall held: queue fills to DEPTH, request drops, then drains and resumes
    apply_reset();
    base = push_cnt;
    repeat (10) step();
    check("stall_pushes", 32'(push_cnt - base), 32'd4);
    check("stall_req_off", {31'd0, imem_req}, 32'd0);
    check("stall_valid", {31'd0, if_valid}, 32'd1);
    check("stall_head", if_pc, 32'd0);
    for (int i = 0; i < 6; i++) sb.push_back(32'(i * 4));
    stall = 1'b0;
    step();
    check("full_idle", {31'd0, imem_req}, 32'd0);
    step();
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h10);
    drain(20);

    // Redirect during an outstanding 3-wait request
    lat   = 3;
    stall = 1'b0;
    apply_reset();
    sb.push_back(32'h100); sb.push_back(32'h104);
    step();
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("drop_req", {31'd0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'd0);
    step();
    check("redir_addr", imem_addr, 32'h100);
    check("redir_valid", {31'd0, if_valid}, 32'd0);
    drain(40);

    // Redirect and exception together: exception wins
    lat = 0;
    apply_reset();
    repeat (8) step();
    check("pre_flush_valid", {31'd0, if_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200; exception = 1'b1;
    step();
    redirect = 1'b0; exception = 1'b0;
    check("flush_empty", {31'd0, if_valid}, 32'd0);
    check("exc_req", {31'd0, imem_req}, 32'd1);
    check("exc_addr", imem_addr, 32'h0000FFFC);
    sb.push_back(32'hFFFC); sb.push_back(32'h10000);
    sb.push_back(32'h10004); sb.push_back(32'h10008);
    repeat (6) step();
    stall = 1'b0;
    drain(20);

    // Fetch PC wrap at the top of the address space
    apply_reset();
    repeat (8) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
    sb.push_back(32'h4); sb.push_back(32'h8);
    repeat (6) step();
    check("wrap_head", if_pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    drain(20);

    // Reset during an outstanding request; a stray late ack is ignored
    lat   = 3;
    stall = 1'b0;
    apply_reset();
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_abandon", {31'd0, imem_req}, 32'd0);
    step();
    reset      = 1'b1;
    ack_inject = 1'b1;
    #1;
    check("late_ack_valid", {31'd0, if_valid}, 32'd0);
    step();
    ack_inject = 1'b0;
    sb.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      check("no_stale_valid", {31'd0, if_valid}, 32'd0);
      step();
    end
    check("refetch_valid", {31'd0, if_valid}, 32'd1);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
